// File: rtl/mul_pack.sv
// mul_pack: result packer for the pipelined floating-point multiplier.
// Normalizes an unrounded significand product, rounds it under the selected
// rounding mode and packs an IEEE-754 word with exception flags.
// Two-stage valid/ready pipeline: stage 1 normalizes, stage 2 rounds/packs.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid / in_ready            input handshake
//   in_sign                        result sign
//   in_expo   [EXPO_W+1:0]         two's-complement biased exponent of in_prod[2*MANT_W]
//   in_prod   [2*MANT_W+1:0]       significand product, value = in_prod * 2^-(2*MANT_W)
//   in_rm     [2:0]                RNE/RTZ/RDN/RUP/RMM (others act as RNE)
//   in_is_nan, in_is_inf, in_invalid  special-case flags from the classifier
//   out_valid / out_ready          output handshake
//   out_data  [EXPO_W+MANT_W:0]    packed result
//   out_nv, out_of, out_uf, out_nx invalid/overflow/underflow/inexact
module mul_pack #(
    parameter int unsigned EXPO_W = 8,
    parameter int unsigned MANT_W = 23
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic [EXPO_W+1:0]        in_expo,
    input  logic [2*MANT_W+1:0]      in_prod,
    input  logic [2:0]               in_rm,
    input  logic                     in_is_nan,
    input  logic                     in_is_inf,
    input  logic                     in_invalid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXPO_W+MANT_W:0]   out_data,
    output logic                     out_nv,
    output logic                     out_of,
    output logic                     out_uf,
    output logic                     out_nx
);

    localparam int unsigned W    = 1 + EXPO_W + MANT_W;
    localparam int unsigned PW   = 2 * MANT_W + 2;        // product width
    localparam int unsigned IB   = 2 * MANT_W;            // integer bit index
    localparam int unsigned XW   = EXPO_W + 3;            // internal exponent width
    localparam int unsigned SAT  = 2 * MANT_W + 3;        // saturating denormal shift
    localparam int unsigned SHW  = $clog2(SAT + 1);
    localparam int unsigned LZW  = $clog2(IB + 1);
    localparam int unsigned EMAX = (1 << EXPO_W) - 1;

    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    typedef enum logic [1:0] {
        CL_FIN  = 2'd0,
        CL_ZERO = 2'd1,
        CL_INF  = 2'd2,
        CL_NAN  = 2'd3
    } cls_e;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s1_adv;
    logic w_s2_adv;

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;

    // ------------------------------------------------------------------
    // Stage 1: classify and normalize
    // ------------------------------------------------------------------
    cls_e                 w_cls;
    logic [LZW-1:0]       w_lz;
    logic [PW-2:0]        w_norm;        // leading one at bit IB
    logic                 w_sticky_hi;   // bit dropped by the >=2.0 right shift
    logic [XW-1:0]        w_expo_x;
    logic [XW-1:0]        w_e_norm;
    logic [XW-1:0]        w_e_neg;
    logic                 w_tiny;
    logic [SHW-1:0]       w_sh;
    logic [PW+SAT-2:0]    w_wide;
    logic [PW-2:0]        w_m;
    logic                 w_lost;

    // Special-case precedence: NaN > inf > zero > finite
    always_comb begin
        w_cls = CL_FIN;
        if (in_is_nan)
            w_cls = CL_NAN;
        else if (in_is_inf)
            w_cls = CL_INF;
        else if (in_prod == '0)
            w_cls = CL_ZERO;
    end

    // Leading-zero count over prod[IB:0]; highest set bit wins
    always_comb begin
        w_lz = '0;
        for (int i = 0; i <= int'(IB); i++) begin
            if (in_prod[i])
                w_lz = LZW'(int'(IB) - i);
        end
    end

    assign w_expo_x = {in_expo[EXPO_W+1], in_expo};

    // Bring the leading one to bit IB and adjust the exponent
    always_comb begin
        w_norm      = '0;
        w_sticky_hi = 1'b0;
        w_e_norm    = w_expo_x;
        if (in_prod[PW-1]) begin
            w_norm      = in_prod[PW-1:1];
            w_sticky_hi = in_prod[0];
            w_e_norm    = w_expo_x + XW'(1);
        end else begin
            w_norm      = in_prod[PW-2:0] << w_lz;
            w_e_norm    = w_expo_x - XW'(w_lz);
        end
    end

    // Exponent <= 0: denormalize by 1-E, saturating so everything lands in sticky
    assign w_tiny  = w_e_norm[XW-1] || (w_e_norm == '0);
    assign w_e_neg = XW'(1) - w_e_norm;

    always_comb begin
        w_sh = '0;
        if (w_tiny) begin
            if (w_e_neg >= XW'(SAT))
                w_sh = SHW'(SAT);
            else
                w_sh = SHW'(w_e_neg);
        end
    end

    // Low SAT bits of the wide vector collect everything shifted out
    assign w_wide = {w_norm, {SAT{1'b0}}} >> w_sh;
    assign w_m    = w_wide[PW+SAT-2 -: PW-1];
    assign w_lost = |w_wide[SAT-1:0];

    logic                 r_s1_sign;
    cls_e                 r_s1_cls;
    logic                 r_s1_nv;
    logic [XW-1:0]        r_s1_exp;
    logic                 r_s1_int;
    logic [MANT_W-1:0]    r_s1_frac;
    logic                 r_s1_g;
    logic                 r_s1_s;
    logic                 r_s1_tiny;
    logic [2:0]           r_s1_rm;

    // Stage 1 register: retains integer bit, fraction, guard and sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_cls   <= CL_FIN;
            r_s1_nv    <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_int   <= 1'b0;
            r_s1_frac  <= '0;
            r_s1_g     <= 1'b0;
            r_s1_s     <= 1'b0;
            r_s1_tiny  <= 1'b0;
            r_s1_rm    <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign <= in_sign;
                r_s1_cls  <= w_cls;
                r_s1_nv   <= in_is_nan && in_invalid;
                r_s1_exp  <= w_tiny ? '0 : w_e_norm;
                r_s1_int  <= w_m[IB];
                r_s1_frac <= w_m[IB-1 -: MANT_W];
                r_s1_g    <= w_m[MANT_W-1];
                r_s1_s    <= (|w_m[MANT_W-2:0]) || w_lost || w_sticky_hi;
                r_s1_tiny <= w_tiny;
                r_s1_rm   <= in_rm;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round, detect overflow, pack
    // ------------------------------------------------------------------
    logic                 w_inexact;
    logic                 w_inc;
    logic [MANT_W+1:0]    w_sum;
    logic                 w_carry;
    logic [XW-1:0]        w_e_rnd;
    logic                 w_ovf;
    logic                 w_ovf_inf;
    logic [W-1:0]         w_data;
    logic                 w_nv;
    logic                 w_of;
    logic                 w_uf;
    logic                 w_nx;

    assign w_inexact = r_s1_g || r_s1_s;

    // Round-increment decision
    always_comb begin
        w_inc     = r_s1_g && (r_s1_s || r_s1_frac[0]);
        w_ovf_inf = 1'b1;
        case (r_s1_rm)
            RM_RTZ: begin
                w_inc     = 1'b0;
                w_ovf_inf = 1'b0;
            end
            RM_RDN: begin
                w_inc     = r_s1_sign && w_inexact;
                w_ovf_inf = r_s1_sign;
            end
            RM_RUP: begin
                w_inc     = !r_s1_sign && w_inexact;
                w_ovf_inf = !r_s1_sign;
            end
            RM_RMM: begin
                w_inc     = r_s1_g;
            end
            default: begin
                w_inc     = r_s1_g && (r_s1_s || r_s1_frac[0]);
                w_ovf_inf = 1'b1;
            end
        endcase
    end

    // A normal carries out of the integer bit; a subnormal carries into it (field -> 1)
    assign w_sum   = {1'b0, r_s1_int, r_s1_frac} + (MANT_W+2)'(w_inc);
    assign w_carry = r_s1_int ? w_sum[MANT_W+1] : w_sum[MANT_W];
    assign w_e_rnd = r_s1_exp + XW'(w_carry);
    assign w_ovf   = !w_e_rnd[XW-1] && (w_e_rnd >= XW'(EMAX));

    always_comb begin
        w_data = '0;
        w_nv   = 1'b0;
        w_of   = 1'b0;
        w_uf   = 1'b0;
        w_nx   = 1'b0;
        case (r_s1_cls)
            CL_NAN: begin
                w_data = {1'b0, {EXPO_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
                w_nv   = r_s1_nv;
            end
            CL_INF: begin
                w_data = {r_s1_sign, {EXPO_W{1'b1}}, {MANT_W{1'b0}}};
            end
            CL_ZERO: begin
                w_data = {r_s1_sign, {EXPO_W{1'b0}}, {MANT_W{1'b0}}};
            end
            default: begin
                w_uf = r_s1_tiny && w_inexact;
                if (w_ovf) begin
                    w_of = 1'b1;
                    w_nx = 1'b1;
                    if (w_ovf_inf)
                        w_data = {r_s1_sign, {EXPO_W{1'b1}}, {MANT_W{1'b0}}};
                    else
                        w_data = {r_s1_sign, {(EXPO_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};
                end else begin
                    w_nx   = w_inexact;
                    w_data = {r_s1_sign, w_e_rnd[EXPO_W-1:0], w_sum[MANT_W-1:0]};
                end
            end
        endcase
    end

    // Stage 2 register doubles as the output register; holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            out_data   <= '0;
            out_nv     <= 1'b0;
            out_of     <= 1'b0;
            out_uf     <= 1'b0;
            out_nx     <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_data <= w_data;
                out_nv   <= w_nv;
                out_of   <= w_of;
                out_uf   <= w_uf;
                out_nx   <= w_nx;
            end
        end
    end

endmodule

// File: tb/tb_mul_pack.sv
// tb_mul_pack: directed self-checking bench for mul_pack (binary32 config).
module tb_mul_pack;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_expo;
    logic [47:0] in_prod;
    logic [2:0]  in_rm;
    logic        in_is_nan;
    logic        in_is_inf;
    logic        in_invalid;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_nv;
    logic        out_of;
    logic        out_uf;
    logic        out_nx;

    int checks;
    int failures;

    typedef struct packed {
        logic        s;
        logic [9:0]  e;
        logic [47:0] p;
        logic [2:0]  rm;
        logic        nan;
        logic        inf;
        logic        inv;
        logic [31:0] d;     // expected data
        logic [3:0]  f;     // expected {nv, of, uf, nx}
    } vec_t;

    mul_pack #(.EXPO_W(8), .MANT_W(23)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_expo    (in_expo),
        .in_prod    (in_prod),
        .in_rm      (in_rm),
        .in_is_nan  (in_is_nan),
        .in_is_inf  (in_is_inf),
        .in_invalid (in_invalid),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_nv     (out_nv),
        .out_of     (out_of),
        .out_uf     (out_uf),
        .out_nx     (out_nx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input vec_t v);
        in_sign    = v.s;
        in_expo    = v.e;
        in_prod    = v.p;
        in_rm      = v.rm;
        in_is_nan  = v.nan;
        in_is_inf  = v.inf;
        in_invalid = v.inv;
    endtask

    // Present one beat with out_ready=1; return the result and edges from accept to out_valid
    task automatic run_beat(input vec_t v, output logic [31:0] d, output logic [3:0] f, output int lat);
        drive(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        d = out_data;
        f = {out_nv, out_of, out_uf, out_nx};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 ||
            {out_nv, out_of, out_uf, out_nx} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b data=%h flags=%b exp valid=0 data=0 flags=0000",
                     out_valid, out_data, {out_nv, out_of, out_uf, out_nx});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_round();
        vec_t v [5];
        logic [31:0] d;
        logic [3:0]  f;
        int          lat;
        v[0] = '{1'b0, 10'd127, 48'h900000000000, 3'd0, 1'b0, 1'b0, 1'b0, 32'h40100000, 4'b0000};
        v[1] = '{1'b0, 10'd127, 48'h400000400000, 3'd0, 1'b0, 1'b0, 1'b0, 32'h3F800000, 4'b0001};
        v[2] = '{1'b0, 10'd127, 48'h400000400000, 3'd3, 1'b0, 1'b0, 1'b0, 32'h3F800001, 4'b0001};
        v[3] = '{1'b0, 10'd127, 48'h400000400000, 3'd4, 1'b0, 1'b0, 1'b0, 32'h3F800001, 4'b0001};
        v[4] = '{1'b0, 10'd127, 48'h7FFFFFC00000, 3'd0, 1'b0, 1'b0, 1'b0, 32'h40000000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            run_beat(v[i], d, f, lat);
            checks++;
            if (lat !== 1) begin
                failures++;
                $display("FAIL round[%0d] latency got=%0d edges exp=1", i, lat);
            end
            checks++;
            if (d !== v[i].d) begin
                failures++;
                $display("FAIL round[%0d] data got=%h exp=%h", i, d, v[i].d);
            end
            checks++;
            if (f !== v[i].f) begin
                failures++;
                $display("FAIL round[%0d] flags got=%b exp=%b", i, f, v[i].f);
            end
        end
    endtask

    task automatic test_overflow();
        vec_t v [5];
        logic [31:0] d;
        logic [3:0]  f;
        int          lat;
        v[0] = '{1'b0, 10'd255, 48'h400000000000, 3'd0, 1'b0, 1'b0, 1'b0, 32'h7F800000, 4'b0101};
        v[1] = '{1'b0, 10'd255, 48'h400000000000, 3'd1, 1'b0, 1'b0, 1'b0, 32'h7F7FFFFF, 4'b0101};
        v[2] = '{1'b1, 10'd255, 48'h400000000000, 3'd2, 1'b0, 1'b0, 1'b0, 32'hFF800000, 4'b0101};
        v[3] = '{1'b0, 10'd255, 48'h400000000000, 3'd2, 1'b0, 1'b0, 1'b0, 32'h7F7FFFFF, 4'b0101};
        v[4] = '{1'b0, 10'd254, 48'h7FFFFFC00000, 3'd0, 1'b0, 1'b0, 1'b0, 32'h7F800000, 4'b0101};
        for (int i = 0; i < 5; i++) begin
            run_beat(v[i], d, f, lat);
            checks++;
            if (d !== v[i].d) begin
                failures++;
                $display("FAIL ovf[%0d] data got=%h exp=%h", i, d, v[i].d);
            end
            checks++;
            if (f !== v[i].f) begin
                failures++;
                $display("FAIL ovf[%0d] flags got=%b exp=%b", i, f, v[i].f);
            end
        end
    endtask

    task automatic test_subnormal();
        vec_t v [3];
        logic [31:0] d;
        logic [3:0]  f;
        int          lat;
        v[0] = '{1'b0, 10'h3EA, 48'h400000000000, 3'd0, 1'b0, 1'b0, 1'b0, 32'h00000001, 4'b0000};
        v[1] = '{1'b0, 10'h3E9, 48'h400000000000, 3'd0, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'b0011};
        v[2] = '{1'b0, 10'd0,   48'h7FFFFFC00000, 3'd0, 1'b0, 1'b0, 1'b0, 32'h00800000, 4'b0011};
        for (int i = 0; i < 3; i++) begin
            run_beat(v[i], d, f, lat);
            checks++;
            if (d !== v[i].d) begin
                failures++;
                $display("FAIL subn[%0d] data got=%h exp=%h", i, d, v[i].d);
            end
            checks++;
            if (f !== v[i].f) begin
                failures++;
                $display("FAIL subn[%0d] flags got=%b exp=%b", i, f, v[i].f);
            end
        end
    endtask

    task automatic test_specials();
        vec_t v [5];
        logic [31:0] d;
        logic [3:0]  f;
        int          lat;
        v[0] = '{1'b1, 10'd127, 48'h400000000000, 3'd0, 1'b1, 1'b0, 1'b1, 32'h7FC00000, 4'b1000};
        v[1] = '{1'b1, 10'd127, 48'h400000000000, 3'd0, 1'b0, 1'b1, 1'b0, 32'hFF800000, 4'b0000};
        v[2] = '{1'b1, 10'd127, 48'h000000000000, 3'd0, 1'b0, 1'b0, 1'b0, 32'h80000000, 4'b0000};
        v[3] = '{1'b0, 10'd127, 48'h400000000000, 3'd0, 1'b1, 1'b1, 1'b0, 32'h7FC00000, 4'b0000};
        v[4] = '{1'b0, 10'd127, 48'h000000000000, 3'd0, 1'b0, 1'b1, 1'b0, 32'h7F800000, 4'b0000};
        for (int i = 0; i < 5; i++) begin
            run_beat(v[i], d, f, lat);
            checks++;
            if (d !== v[i].d) begin
                failures++;
                $display("FAIL spec[%0d] data got=%h exp=%h", i, d, v[i].d);
            end
            checks++;
            if (f !== v[i].f) begin
                failures++;
                $display("FAIL spec[%0d] flags got=%b exp=%b", i, f, v[i].f);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t a;
        vec_t b;
        vec_t c;
        a = '{1'b0, 10'd127, 48'h400000400000, 3'd0, 1'b0, 1'b0, 1'b0, 32'h3F800000, 4'b0001};
        b = '{1'b0, 10'd127, 48'h900000000000, 3'd0, 1'b0, 1'b0, 1'b0, 32'h40100000, 4'b0000};
        c = '{1'b0, 10'd127, 48'h400000400000, 3'd3, 1'b0, 1'b0, 1'b0, 32'h3F800001, 4'b0001};
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(a);
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_accept0 in_ready got=%b exp=1", in_ready);
        end
        @(posedge clk); #1;
        drive(b);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_accept1 in_ready got=%b exp=1", in_ready);
        end
        @(posedge clk); #1;
        drive(c);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_refuse2 in_ready got=%b exp=0", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== a.d || in_ready !== 1'b0 ||
                {out_nv, out_of, out_uf, out_nx} !== a.f) begin
                failures++;
                $display("FAIL bp_stall[%0d] got valid=%b data=%h flags=%b ready=%b exp valid=1 data=%h flags=%b ready=0",
                         i, out_valid, out_data, {out_nv, out_of, out_uf, out_nx}, in_ready, a.d, a.f);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release in_ready got=%b exp=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== b.d) begin
            failures++;
            $display("FAIL bp_order1 got valid=%b data=%h exp valid=1 data=%h", out_valid, out_data, b.d);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== c.d) begin
            failures++;
            $display("FAIL bp_order2 got valid=%b data=%h exp valid=1 data=%h", out_valid, out_data, c.d);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drained out_valid got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        vec_t a;
        logic stale;
        a = '{1'b0, 10'd127, 48'h900000000000, 3'd0, 1'b0, 1'b0, 1'b0, 32'h40100000, 4'b0000};
        out_ready = 1'b0;
        drive(a);
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_fill got valid=%b ready=%b exp valid=1 ready=0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_async got valid=%b data=%h ready=%b exp valid=0 data=0 ready=1",
                     out_valid, out_data, in_ready);
        end
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        stale     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0)
                stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_stale saw out_valid=1 after reset exp none");
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        in_sign    = 1'b0;
        in_expo    = '0;
        in_prod    = '0;
        in_rm      = '0;
        in_is_nan  = 1'b0;
        in_is_inf  = 1'b0;
        in_invalid = 1'b0;
        test_reset();
        test_round();
        test_overflow();
        test_subnormal();
        test_specials();
        test_back_to_back();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
